// File: rtl/ram_partitioned_onehot_reinit_pkg.sv
// ram_part_pkg: shared types and init-value selectors for the partitioned one-hot RAM.
package ram_part_pkg;
   typedef enum logic [1:0] {GATED, INIT, READY} part_state_t;
   localparam int RAM_RESET_ZERO = 0;
   localparam int RAM_RESET_SEQ  = 1;
endpackage

// File: rtl/ram_partitioned_onehot_reinit_if.sv
// ram_partitioned_onehot_reinit_if: read/write/gating bus of the partitioned one-hot RAM.
interface ram_partitioned_onehot_reinit_if #(
   parameter int DEPTH         = 64,
   parameter int WIDTH         = 32,
   parameter int NUM_RD_PORTS  = 4,
   parameter int NUM_WR_PORTS  = 2,
   parameter int NUM_PARTS     = 4,
   parameter int NUM_PARTS_LOG = 2
);
   logic [NUM_PARTS-1:0]                         partitionGated_i;
   logic [NUM_RD_PORTS-1:0][NUM_PARTS_LOG-1:0]   rdDataPartition_i;
   logic [NUM_RD_PORTS-1:0][DEPTH-1:0]           addr_i;
   logic [NUM_RD_PORTS-1:0][WIDTH-1:0]           data_o;
   logic [NUM_WR_PORTS-1:0][DEPTH-1:0]           addrWr_i;
   logic [NUM_WR_PORTS-1:0][WIDTH-1:0]           dataWr_i;
   logic [NUM_WR_PORTS-1:0]                      wrEn_i;
   logic [NUM_PARTS-1:0]                         partReady_o;
   logic                                         ramReady_o;
   modport master (
      output partitionGated_i, rdDataPartition_i, addr_i, addrWr_i, dataWr_i, wrEn_i,
      input  data_o, partReady_o, ramReady_o
   );
   modport slave (
      input  partitionGated_i, rdDataPartition_i, addr_i, addrWr_i, dataWr_i, wrEn_i,
      output data_o, partReady_o, ramReady_o
   );
endinterface

// File: rtl/ram_partitioned_onehot_reinit_ctrl.sv
// ram_partition_ctrl: GATED/INIT/READY lifecycle of one partition; sweeps every row once after un-gating.
module ram_partition_ctrl
   import ram_part_pkg::*;
#(
   parameter int PD        = 16,
   parameter int PD_LOG    = 4,
   parameter int WIDTH     = 32,
   parameter int RESET_VAL = RAM_RESET_ZERO,
   parameter int SEQ_START = 0,
   parameter int BASE      = 0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              gate_i,
   output logic              initEn_o,
   output logic [PD_LOG-1:0] initRow_o,
   output logic [WIDTH-1:0]  initData_o,
   output logic              ready_o
);
   part_state_t       state_q, state_d;
   logic [PD_LOG-1:0] cnt_q, cnt_d;
   logic              last;
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         state_q <= gate_i ? GATED : INIT;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   assign last = cnt_q == PD_LOG'(PD - 1);
   always_comb begin
      state_d = state_q;
      cnt_d   = '0;
      if (gate_i) state_d = GATED;
      else if (state_q == GATED) state_d = INIT;
      else if (state_q == INIT) begin
         state_d = last ? READY : INIT;
         cnt_d   = last ? '0 : cnt_q + PD_LOG'(1);
      end
   end
   assign initEn_o   = state_q == INIT;
   assign initRow_o  = cnt_q;
   assign initData_o = RESET_VAL == RAM_RESET_SEQ ? WIDTH'(SEQ_START + BASE + int'(cnt_q)) : '0;
   assign ready_o    = state_q == READY;
endmodule

// File: rtl/ram_partitioned_onehot_reinit.sv
// ram_partitioned_onehot_reinit: one-hot multi-port RAM split into power-gateable partitions
// that re-initialise themselves after un-gating.
module ram_partitioned_onehot_reinit
   import ram_part_pkg::*;
#(
   parameter int DEPTH         = 64,
   parameter int WIDTH         = 32,
   parameter int NUM_RD_PORTS  = 4,
   parameter int NUM_WR_PORTS  = 2,
   parameter int NUM_PARTS     = 4,
   parameter int NUM_PARTS_LOG = 2,
   parameter int RESET_VAL     = RAM_RESET_ZERO,
   parameter int SEQ_START     = 0,
   parameter int RD_REGISTERED = 0
) (
   input logic clk,
   input logic reset,
   ram_partitioned_onehot_reinit_if.slave bus
);
   localparam int PD     = DEPTH / NUM_PARTS;
   localparam int PD_LOG = PD > 1 ? $clog2(PD) : 1;
   logic [WIDTH-1:0]                    mem_q [DEPTH];
   logic [WIDTH-1:0]                    mem_d [DEPTH];
   logic [NUM_PARTS-1:0]                init_en, ready;
   logic [PD_LOG-1:0]                   init_row [NUM_PARTS];
   logic [WIDTH-1:0]                    init_data [NUM_PARTS];
   logic [NUM_RD_PORTS-1:0][WIDTH-1:0]  rd_d, rd_q;
   for (genvar g = 0; g < NUM_PARTS; g++) begin : g_part
      ram_partition_ctrl #(
         .PD(PD), .PD_LOG(PD_LOG), .WIDTH(WIDTH), .RESET_VAL(RESET_VAL),
         .SEQ_START(SEQ_START), .BASE(g * PD)
      ) u_ctrl (
         .clk        (clk),
         .reset      (reset),
         .gate_i     (bus.partitionGated_i[g]),
         .initEn_o   (init_en[g]),
         .initRow_o  (init_row[g]),
         .initData_o (init_data[g]),
         .ready_o    (ready[g])
      );
   end
   // Later write ports overwrite earlier ones; init and user writes never overlap since INIT is not READY.
   always_comb begin
      for (int r = 0; r < DEPTH; r++) begin
         mem_d[r] = mem_q[r];
         for (int w = 0; w < NUM_WR_PORTS; w++)
            if (ready[r/PD] && bus.wrEn_i[w] && bus.addrWr_i[w][r]) mem_d[r] = bus.dataWr_i[w];
         if (init_en[r/PD] && int'(init_row[r/PD]) == r % PD) mem_d[r] = init_data[r/PD];
      end
   end
   always_ff @(posedge clk) mem_q <= mem_d;
   // Partition select folded into the wired-OR; an out-of-range select matches no row.
   always_comb begin
      for (int p = 0; p < NUM_RD_PORTS; p++) begin
         rd_d[p] = '0;
         for (int r = 0; r < DEPTH; r++)
            if (bus.addr_i[p][r] && ready[r/PD] && int'(bus.rdDataPartition_i[p]) == r / PD)
               rd_d[p] = rd_d[p] | mem_q[r];
      end
   end
   always_ff @(posedge clk or posedge reset)
      if (reset) rd_q <= '0;
      else rd_q <= rd_d;
   assign bus.data_o      = RD_REGISTERED != 0 ? rd_q : rd_d;
   assign bus.partReady_o = ready;
   assign bus.ramReady_o  = &(ready | bus.partitionGated_i);
endmodule

// File: doc/ram_partitioned_onehot_reinit.md
Name: ram_partitioned_onehot_reinit

Overview:
- Multi-port RAM addressed by one-hot word lines, split into NUM_PARTS equal partitions that can each be power-gated independently.
- Successor to the fixed 8-way partitioned no-decode RAM:
  - read-partition mux is generic in NUM_PARTS;
  - optional registered read;
  - each partition has its own lifecycle FSM that re-initialises it after un-gating, with per-partition and global ready flags.
- Used for rename/free-list/ROB-style structures that shrink and grow at runtime.

Parameters:
- DEPTH, 64, total rows; must be a multiple of NUM_PARTS.
- WIDTH, 32, bits per row.
- NUM_RD_PORTS, 4, read ports.
- NUM_WR_PORTS, 2, write ports.
- NUM_PARTS, 4, partitions; PD = DEPTH/NUM_PARTS rows each.
- NUM_PARTS_LOG, 2, clog2(NUM_PARTS), minimum 1.
- RESET_VAL, RAM_RESET_ZERO, init value: ZERO (all 0) or SEQ (row index + SEQ_START).
- SEQ_START, 0, base of the SEQ init value.
- RD_REGISTERED, 0, 1 = data_o registered with 1-cycle latency.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high.
- partitionGated_i  in  NUM_PARTS  1 = partition powered off.
- rdDataPartition_i  in  NUM_RD_PORTS x NUM_PARTS_LOG  partition selected per read port.
- addr_i  in  NUM_RD_PORTS x DEPTH  one-hot read word lines.
- data_o  out  NUM_RD_PORTS x WIDTH  read data.
- addrWr_i  in  NUM_WR_PORTS x DEPTH  one-hot write word lines.
- dataWr_i  in  NUM_WR_PORTS x WIDTH  write data.
- wrEn_i  in  NUM_WR_PORTS  write enable per port.
- partReady_o  out  NUM_PARTS  partition in READY state.
- ramReady_o  out  1  every non-gated partition READY.

Behaviour:
- Reset values:
  - every FSM goes to INIT, or GATED if its gate bit is 1; init counters = 0.
  - partReady_o = 0, ramReady_o = 0, data_o = 0 (registered copy also 0).
- Partition p owns rows [p*PD, (p+1)*PD).
- Per-partition FSM, states GATED / INIT / READY:
  - GATED -> INIT when the gate bit is 0. Contents are lost; INIT restarts with cnt = 0.
  - INIT writes one row per cycle: row p*PD+cnt gets 0 (ZERO) or SEQ_START+p*PD+cnt (SEQ).
  - INIT -> READY the cycle after cnt = PD-1, so INIT lasts exactly PD cycles.
  - Any state -> GATED, on the next edge, whenever the gate bit is 1. This includes mid-INIT; cnt is cleared.
- partReady_o[p] = (state == READY).
- ramReady_o = AND over p of (partReady_o[p] | partitionGated_i[p]).
  - If every partition is gated, ramReady_o = 1.
- Writes:
  - Take effect at the clock edge, to every row whose word line is set, only if wrEn_i is set and the owning partition is READY.
  - Writes to GATED or INIT partitions are silently dropped; INIT data always wins.
  - Two ports writing the same row in the same cycle: the highest-numbered port wins.
- Reads:
  - Per port, per partition: the OR of all rows selected by addr_i within that partition (wired-OR model). No word line set gives 0.
  - A partition that is not READY contributes 0.
  - data_o[rp] = partition output selected by rdDataPartition_i[rp]; an index >= NUM_PARTS gives 0.
  - Read-during-write to the same row returns old data.
- RD_REGISTERED=1: the same value is captured at the edge and appears one cycle later.
- Asynchronous reset asserted mid-INIT or mid-operation: immediate return to reset values. Contents are not guaranteed until INIT completes again.

Decomposition:
- Package ram_part_pkg holds:
  - enum part_state_t {GATED, INIT, READY};
  - constants RAM_RESET_ZERO and RAM_RESET_SEQ.
- Sub-module ram_partition_ctrl, one instance per partition: FSM plus clog2(PD)-bit init counter. Outputs initEn, initRow, initData and ready.
- The storage array, write-priority logic and read mux stay in the top module.

Test Plan (DEPTH=64, NUM_PARTS=4, PD=16, SEQ, SEQ_START=0 unless noted):
- Reset release with no gates -> ramReady_o rises exactly 16 cycles later; read row 20 with partition 1 selected -> data_o=20; read row 63 with partition 3 selected -> 63.
- Write 0xDEAD to row 5 on port 0 and 0xBEEF on port 1 in the same cycle -> row 5 reads 0xBEEF. Combinational read of row 5 in that write cycle -> old value 5.
- Gate partition 2 for 3 cycles, then un-gate; write row 35 during INIT:
  - partReady_o[2] low for 3+16 cycles;
  - ramReady_o is 1 while the partition is gated, 0 during INIT;
  - the write is dropped and row 35 reads 35 afterwards.
- Set read word lines for rows 1 and 2 (partition 0) after writing 0x10 and 0x03 -> data_o=0x13. No word line set -> 0. rdDataPartition_i selecting gated partition 3 -> 0.
- RD_REGISTERED=1, read row 7 at cycle N -> data_o=7 at N+1 and 0 at N.
- Assert reset at cycle 8 of INIT, release -> ramReady_o low, then high 16 cycles after release; RESET_VAL=ZERO -> all rows read 0.
